// File: rtl/aes_pkg.sv
// Shared AES constants: key-schedule sizes, round constants, controller states
// and the forward S-box table used by key expansion and the cipher rounds.
package aes_pkg;

  localparam int unsigned NR   = 32'd14;
  localparam int unsigned NK   = 32'd8;
  localparam int unsigned RK_W = 32'd128;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon_at(input logic [2:0] i);
    logic [7:0] r;
    case (i)
      3'd0:    r = 8'h01;
      3'd1:    r = 8'h02;
      3'd2:    r = 8'h04;
      3'd3:    r = 8'h08;
      3'd4:    r = 8'h10;
      3'd5:    r = 8'h20;
      3'd6:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// 8-bit combinational AES forward S-box; also used by the cipher round logic.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = SBOX_TABLE[11'd2047 - {din, 3'b000} -: 8];

endmodule

// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: one 128-bit round key per cycle into a
// 15-entry register file. Optional key cache under `AES_KEY_CACHE_EN.
module aes256_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NR = 32'd14
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [255:0]   key,
  input  logic [3:0]     rk_idx,
  output logic [127:0]   rk_out,
  output logic           busy,
  output logic           done,
  output logic           key_valid
);

  if (NR != aes_pkg::NR) begin : g_bad_nr
    $error("aes256_key_expand: NR must be 14");
  end

  localparam logic [3:0] LAST_IDX = 4'd14;

  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              key_valid_r, key_valid_s;
  logic              load_s, exp_wr_s, cache_hit_s;
  logic [RK_W-1:0]   rk_r [0:NR];

  logic [127:0]      prev2_s;
  logic [31:0]       t_s, sub_in_s, sub_out_s, f_s;
  logic [31:0]       w0_s, w1_s, w2_s, w3_s;

`ifdef AES_KEY_CACHE_EN
  logic [255:0]      last_key_r;

  // Remember the key behind the current register-file contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_key_r <= 256'h0;
    end else if (load_s) begin
      last_key_r <= key;
    end
  end

  assign cache_hit_s = key_valid_r && (key == last_key_r);
`else
  assign cache_hit_s = 1'b0;
`endif

  // Word chain: rk[cnt] derived from rk[cnt-2] and the last word of rk[cnt-1].
  assign prev2_s  = rk_r[cnt_r - 4'd2];
  assign t_s      = rk_r[cnt_r - 4'd1][31:0];
  assign sub_in_s = cnt_r[0] ? t_s : {t_s[23:0], t_s[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (sub_in_s[8*g +: 8]),
      .dout (sub_out_s[8*g +: 8])
    );
  end

  assign f_s  = cnt_r[0] ? sub_out_s
                         : (sub_out_s ^ {rcon_at(cnt_r[3:1] - 3'd1), 24'h000000});
  assign w0_s = prev2_s[127:96] ^ f_s;
  assign w1_s = prev2_s[95:64]  ^ w0_s;
  assign w2_s = prev2_s[63:32]  ^ w1_s;
  assign w3_s = prev2_s[31:0]   ^ w2_s;

  // Next-state and control decode.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    key_valid_s = key_valid_r;
    load_s      = 1'b0;
    exp_wr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && cache_hit_s) begin
          done_s = 1'b1;
        end else if (start) begin
          load_s      = 1'b1;
          cnt_s       = 4'd2;
          busy_s      = 1'b1;
          key_valid_s = 1'b0;
          state_s     = EXPAND;
        end else begin
          state_s = IDLE;
        end
      end
      EXPAND: begin
        exp_wr_s = 1'b1;
        if (cnt_r == LAST_IDX) begin
          cnt_s       = 4'd0;
          done_s      = 1'b1;
          key_valid_s = 1'b1;
          busy_s      = 1'b0;
          state_s     = IDLE;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Controller state and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      key_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      key_valid_r <= key_valid_s;
    end
  end

  // Round-key register file; reset wipes every entry so no partial keys survive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i <= NR; i++) begin
        rk_r[i] <= 128'h0;
      end
    end else if (load_s) begin
      rk_r[0] <= key[255:128];
      rk_r[1] <= key[127:0];
    end else if (exp_wr_s) begin
      rk_r[cnt_r] <= {w0_s, w1_s, w2_s, w3_s};
    end
  end

  assign rk_out    = (rk_idx <= LAST_IDX) ? rk_r[rk_idx] : 128'h0;
  assign busy      = busy_r;
  assign done      = done_r;
  assign key_valid = key_valid_r;

endmodule

// File: tb/tb_aes256_key_expand.sv
// Self-checking bench for aes256_key_expand using a scoreboard of expected
// round keys per accepted start; exercises `AES_KEY_CACHE_EN when defined.
module tb_aes256_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] key;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         busy, done, key_valid;

  localparam logic [255:0] K1      = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K1_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] K1_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [255:0] K2      = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] K2_RK2  = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] K2_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] val;
  } sb_t;

  sb_t sb_q[$];
  sb_t sb_e;
  int  n_checks = 0;
  int  n_pass   = 0;

  aes256_key_expand dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key       (key),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic push_job(input logic [255:0] k, input logic [127:0] r2, input logic [127:0] r14);
    sb_q.push_back({4'd0, k[255:128]});
    sb_q.push_back({4'd1, k[127:0]});
    sb_q.push_back({4'd2, r2});
    sb_q.push_back({4'd14, r14});
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; key = 256'h0; rk_idx = 4'd0;
    #2;
    n_checks++;
    if ({busy, done, key_valid} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {busy, done, key_valid});
    else n_pass++;
    for (int i = 0; i < 16; i += 7) begin
      rk_idx = 4'(i); #1;
      n_checks++;
      if (rk_out !== 128'h0) $display("FAIL reset_rk%0d got %h exp 0", i, rk_out);
      else n_pass++;
    end
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, key_valid} !== 3'b000) $display("FAIL post_reset_flags got %b exp 000", {busy, done, key_valid});
    else n_pass++;
  endtask

  task automatic test_fips_a3;
    int n;
    push_job(K1, K1_RK2, K1_RK14);
    key = K1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if ({busy, key_valid} !== 2'b10) $display("FAIL a3_busy got %b exp 10", {busy, key_valid});
    else n_pass++;
    wait_done(n);
    n_checks++;
    if (n !== 13) $display("FAIL a3_latency got %0d exp 13", n);
    else n_pass++;
    n_checks++;
    if ({busy, key_valid} !== 2'b01) $display("FAIL a3_done_flags got %b exp 01", {busy, key_valid});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      sb_e = sb_q.pop_front();
      rk_idx = sb_e.idx; #1;
      n_checks++;
      if (rk_out !== sb_e.val) $display("FAIL a3_rk%0d got %h exp %h", sb_e.idx, rk_out, sb_e.val);
      else n_pass++;
    end
    rk_idx = 4'd15; #1;
    n_checks++;
    if (rk_out !== 128'h0) $display("FAIL a3_rk15 got %h exp 0", rk_out);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({done, key_valid} !== 2'b01) $display("FAIL a3_pulse got %b exp 01", {done, key_valid});
    else n_pass++;
  endtask

  task automatic test_key_c3;
    int n;
    push_job(K2, K2_RK2, K2_RK14);
    key = K2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key = K1;
    wait_done(n);
    n_checks++;
    if (n !== 13) $display("FAIL c3_latency got %0d exp 13", n);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      sb_e = sb_q.pop_front();
      rk_idx = sb_e.idx; #1;
      n_checks++;
      if (rk_out !== sb_e.val) $display("FAIL c3_rk%0d got %h exp %h", sb_e.idx, rk_out, sb_e.val);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_start;
    int n;
    int pulses;
    push_job(K1, K1_RK2, K1_RK14);
    key = K1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    key = 256'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL ign_busy got %b exp 1", busy);
    else n_pass++;
    wait_done(n);
    n_checks++;
    if (n + 3 !== 13) $display("FAIL ign_latency got %0d exp 13", n + 3);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      sb_e = sb_q.pop_front();
      rk_idx = sb_e.idx; #1;
      n_checks++;
      if (rk_out !== sb_e.val) $display("FAIL ign_rk%0d got %h exp %h", sb_e.idx, rk_out, sb_e.val);
      else n_pass++;
    end
    pulses = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL ign_extra_done got %0d exp 0", pulses);
    else n_pass++;
  endtask

  task automatic test_reset_abort;
    int n;
    key = K1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++;
    if (busy !== 1'b1) $display("FAIL abort_busy_before got %b exp 1", busy);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, key_valid} !== 3'b000) $display("FAIL abort_flags got %b exp 000", {busy, done, key_valid});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      rk_idx = 4'(i); #1;
      n_checks++;
      if (rk_out !== 128'h0) $display("FAIL abort_rk%0d got %h exp 0", i, rk_out);
      else n_pass++;
    end
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    push_job(K2, K2_RK2, K2_RK14);
    key = K2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    n_checks++;
    if (n !== 13) $display("FAIL abort_restart_latency got %0d exp 13", n);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      sb_e = sb_q.pop_front();
      rk_idx = sb_e.idx; #1;
      n_checks++;
      if (rk_out !== sb_e.val) $display("FAIL abort_rk%0d got %h exp %h", sb_e.idx, rk_out, sb_e.val);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int n;
    push_job(K1, K1_RK2, K1_RK14);
    key = K1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    push_job(K2, K2_RK2, K2_RK14);
    key = K2; start = 1'b1;
    wait_done(n);
    n_checks++;
    if (n + 10 !== 13) $display("FAIL b2b_first_latency got %0d exp 13", n + 10);
    else n_pass++;
    n_checks++;
    if (key_valid !== 1'b1) $display("FAIL b2b_first_valid got %b exp 1", key_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      sb_e = sb_q.pop_front();
      rk_idx = sb_e.idx; #1;
      n_checks++;
      if (rk_out !== sb_e.val) $display("FAIL b2b_a_rk%0d got %h exp %h", sb_e.idx, rk_out, sb_e.val);
      else n_pass++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if ({busy, done, key_valid} !== 3'b100) $display("FAIL b2b_second_start got %b exp 100", {busy, done, key_valid});
    else n_pass++;
    wait_done(n);
    n_checks++;
    if (n !== 13) $display("FAIL b2b_second_latency got %0d exp 13", n);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      sb_e = sb_q.pop_front();
      rk_idx = sb_e.idx; #1;
      n_checks++;
      if (rk_out !== sb_e.val) $display("FAIL b2b_b_rk%0d got %h exp %h", sb_e.idx, rk_out, sb_e.val);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cache;
    int n;
    push_job(K2, K2_RK2, K2_RK14);
    key = K2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef AES_KEY_CACHE_EN
    n_checks++;
    if ({done, busy, key_valid} !== 3'b101) $display("FAIL cache_hit got %b exp 101", {done, busy, key_valid});
    else n_pass++;
`else
    n_checks++;
    if (busy !== 1'b1) $display("FAIL nocache_busy got %b exp 1", busy);
    else n_pass++;
    wait_done(n);
    n_checks++;
    if (n !== 13) $display("FAIL nocache_latency got %0d exp 13", n);
    else n_pass++;
`endif
    for (int i = 0; i < 4; i++) begin
      sb_e = sb_q.pop_front();
      rk_idx = sb_e.idx; #1;
      n_checks++;
      if (rk_out !== sb_e.val) $display("FAIL cache_rk%0d got %h exp %h", sb_e.idx, rk_out, sb_e.val);
      else n_pass++;
    end
    @(posedge clk); #1;
    push_job(K1, K1_RK2, K1_RK14);
    key = K1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    n_checks++;
    if (n !== 13) $display("FAIL cache_miss_latency got %0d exp 13", n);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      sb_e = sb_q.pop_front();
      rk_idx = sb_e.idx; #1;
      n_checks++;
      if (rk_out !== sb_e.val) $display("FAIL cache_miss_rk%0d got %h exp %h", sb_e.idx, rk_out, sb_e.val);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fips_a3();
    test_key_c3();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_cache();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
